seq_match_logger: RTL and testbench

- Sits directly downstream of the non-overlapping 1010 Mealy detector and consumes its one-cycle detect pulse.
- Timestamps each detection with the bit position in the serial stream (one bit per enabled clk).
- Buffers the timestamps in a small FIFO for a host reader, keeps a saturating match count, and flags non-overlap spacing violations.

---
 rtl/seq_match_logger.sv | 165 ++++++++++++++++
 tb/tb_seq_match_logger.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_logger.sv
// seq_match_logger: timestamps detections from an upstream serial pattern detector.
//
// Each enabled clock advances a bit-position counter. A detect pulse captures the
// position of that same bit into a small FIFO for a host reader. The block also
// keeps a saturating match count and flags matches spaced closer than MIN_GAP bits.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   en          stream-advance qualifier, one serial bit per enabled cycle
//   clear       synchronous clear of counters, FIFO and flags (rd_data holds)
//   det_in      detect pulse from upstream detector
//   rd_en       pop request from reader
//   rd_data     popped bit position, registered
//   rd_valid    one-cycle strobe qualifying rd_data
//   empty       FIFO holds zero entries
//   full        FIFO holds DEPTH entries
//   overflow    sticky: a detection was dropped because the FIFO was full
//   gap_err     sticky: two matches were closer than MIN_GAP bits
//   match_count saturating number of detections seen
module seq_match_logger #(
  parameter int unsigned POS_W   = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             det_in,
  input  logic             rd_en,
  output logic [POS_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             gap_err,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
  localparam logic [POS_W-1:0] MinGapPos = POS_W'(MIN_GAP);

  logic [POS_W-1:0] mem [DEPTH];

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] last_pos_q;
  logic             have_last_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [POS_W-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             empty_q;
  logic             full_q;
  logic             overflow_q;
  logic             gap_err_q;
  logic [CNT_W-1:0] match_count_q;

  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;
  logic [POS_W-1:0] diff;
  logic             too_close;

  // A detection only counts when the stream advances on this cycle.
  assign capture = en & det_in;
  assign pop     = rd_en & ~empty_q;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push    = capture & (~full_q | pop);
  assign drop    = capture & full_q & ~pop;

  // Modular subtraction handles spacing across the position-counter wrap.
  assign diff      = pos_q - last_pos_q;
  assign too_close = have_last_q & (diff < MinGapPos);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_q] <= pos_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q         <= '0;
      last_pos_q    <= '0;
      have_last_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      gap_err_q     <= 1'b0;
      match_count_q <= '0;
    end else if (clear) begin
      // rd_data deliberately holds across a clear.
      pos_q         <= '0;
      last_pos_q    <= '0;
      have_last_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_valid_q    <= 1'b0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      gap_err_q     <= 1'b0;
      match_count_q <= '0;
    end else begin
      if (en) begin
        pos_q <= pos_q + POS_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      rd_valid_q <= pop;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == DepthCnt);
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (capture) begin
        if (match_count_q != {CNT_W{1'b1}}) begin
          match_count_q <= match_count_q + CNT_W'(1);
        end
        if (too_close) begin
          gap_err_q <= 1'b1;
        end
        have_last_q <= 1'b1;
        last_pos_q  <= pos_q;
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign overflow    = overflow_q;
  assign gap_err     = gap_err_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_match_logger.sv
module tb_seq_match_logger;

  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clear;
  logic       det_in;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       gap_err;
  logic [7:0] match_count;

  logic [7:0] rd_data3;
  logic       rd_valid3;
  logic       empty3;
  logic       full3;
  logic       overflow3;
  logic       gap_err3;
  logic [2:0] match_count3;

  seq_match_logger #(.POS_W(8), .CNT_W(8), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) u_dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .det_in(det_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .overflow(overflow), .gap_err(gap_err), .match_count(match_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  seq_match_logger #(.POS_W(8), .CNT_W(3), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .det_in(det_in), .rd_en(rd_en),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .empty(empty3), .full(full3),
    .overflow(overflow3), .gap_err(gap_err3), .match_count(match_count3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of positions plus plain integer bookkeeping.
  int m_pos;
  int m_q[$];
  int m_cnt;
  int m_cnt3;
  bit m_have;
  int m_last;
  bit m_gap;
  bit m_ovf;
  bit m_rv;
  int m_rd;

  typedef struct {
    bit en;
    bit clr;
    bit det;
    bit rd;
    bit e_rv;
    int e_rd;
    bit e_empty;
    bit e_full;
    int e_cnt;
    bit e_gap;
    bit e_ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input bit keep_rd);
    m_pos  = 0;
    m_q.delete();
    m_cnt  = 0;
    m_cnt3 = 0;
    m_have = 0;
    m_last = 0;
    m_gap  = 0;
    m_ovf  = 0;
    m_rv   = 0;
    if (!keep_rd) m_rd = 0;
  endtask

  task automatic model_step();
    int sz;
    bit pop_ok;
    bit cap;
    if (clear) begin
      model_reset(1'b1);
      return;
    end
    sz     = m_q.size();
    pop_ok = rd_en && (sz > 0);
    cap    = en && det_in;
    m_rv   = pop_ok;
    if (pop_ok) m_rd = m_q.pop_front();
    if (cap) begin
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_cnt3 = (m_cnt3 < 7) ? m_cnt3 + 1 : 7;
      if (sz < DEPTH || pop_ok) m_q.push_back(m_pos);
      else m_ovf = 1;
      if (m_have && (((m_pos - m_last) + 256) % 256) < MIN_GAP) m_gap = 1;
      m_have = 1;
      m_last = m_pos;
    end
    if (en) m_pos = (m_pos + 1) % 256;
  endtask

  task automatic check_all();
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("gap_err", 32'(gap_err), 32'(m_gap));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("match_count_w3", 32'(match_count3), 32'(m_cnt3));
    chk("rd_valid_w3", 32'(rd_valid3), 32'(m_rv));
  endtask

  task automatic drive(input bit e, input bit c, input bit d, input bit r);
    en     = e;
    clear  = c;
    det_in = d;
    rd_en  = r;
  endtask

  // Apply inputs for one cycle, advance the model, sample 1 ns after the edge.
  task automatic cyc(input bit e, input bit c, input bit d, input bit r);
    drive(e, c, d, r);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse away from any clock edge; outputs must respond at once.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset(1'b0);
    check_all();
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    m_rd = 0;
    do_reset();

    // Directed table: 1010 hits at pos 4 and 12, then drain.
    for (int i = 0; i < 15; i++) begin
      tbl[i] = '{en: 1, clr: 0, det: (i == 4 || i == 12), rd: 0, e_rv: 0, e_rd: 0,
                 e_empty: (i < 4), e_full: 0,
                 e_cnt: (i >= 12) ? 2 : ((i >= 4) ? 1 : 0), e_gap: 0, e_ovf: 0};
    end
    tbl[15] = '{en: 0, clr: 0, det: 0, rd: 1, e_rv: 1, e_rd: 4, e_empty: 0, e_full: 0,
                e_cnt: 2, e_gap: 0, e_ovf: 0};
    tbl[16] = '{en: 0, clr: 0, det: 0, rd: 1, e_rv: 1, e_rd: 12, e_empty: 1, e_full: 0,
                e_cnt: 2, e_gap: 0, e_ovf: 0};
    tbl[17] = '{en: 0, clr: 0, det: 0, rd: 1, e_rv: 0, e_rd: 12, e_empty: 1, e_full: 0,
                e_cnt: 2, e_gap: 0, e_ovf: 0};
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].en, tbl[i].clr, tbl[i].det, tbl[i].rd);
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].e_rv));
      chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].e_rd));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e_empty));
      chk("tbl_full", 32'(full), 32'(tbl[i].e_full));
      chk("tbl_count", 32'(match_count), 32'(tbl[i].e_cnt));
      chk("tbl_gap", 32'(gap_err), 32'(tbl[i].e_gap));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Gap violation at pos 3 and 5, sticky through a legal match.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, (i == 3 || i == 5 || i == 9), 1'b0);
    chk("gap_set", 32'(gap_err), 32'd1);
    for (int i = 10; i < 15; i++) cyc(1'b1, 1'b0, (i == 13), 1'b0);
    chk("gap_sticky", 32'(gap_err), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_cleared", 32'(gap_err), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, (i == 10 || i == 14), 1'b0);
    chk("gap_exact_min", 32'(gap_err), 32'd0);

    // Fill past depth, then push-with-pop while full.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, (i % 4 == 0), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_count", 32'(match_count), 32'd5);
    for (int i = 17; i < 21; i++) cyc(1'b1, 1'b0, (i == 20), (i == 20));
    chk("fullpop_full", 32'(full), 32'd1);
    chk("fullpop_rv", 32'(rd_valid), 32'd1);
    chk("fullpop_data", 32'(rd_data), 32'd0);
    chk("fullpop_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_0", 32'(rd_data), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_1", 32'(rd_data), 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_2", 32'(rd_data), 32'd12);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_3", 32'(rd_data), 32'd20);
    chk("drain_empty", 32'(empty), 32'd1);

    // Position wrap: matches at 254 and 2 are exactly MIN_GAP apart.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 259; i++) cyc(1'b1, 1'b0, (i == 254 || i == 258), 1'b0);
    chk("wrap_gap", 32'(gap_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_rd0", 32'(rd_data), 32'd254);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_rd1", 32'(rd_data), 32'd2);

    // Saturation of the 3-bit counter; det_in without en is ignored.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_w3", 32'(match_count3), 32'd7);
    chk("sat_w8", 32'(match_count), 32'd10);

    // Mid-cycle async reset with three entries buffered and a pending pop.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, (i % 4 == 0), 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    #3;
    do_reset();
    chk("areset_empty", 32'(empty), 32'd1);
    chk("areset_count", 32'(match_count), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear with entries buffered and det/rd active; rd_data holds.
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, (i > 0 && i % 4 == 0), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("preclear_rd", 32'(rd_data), 32'd4);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_rv", 32'(rd_valid), 32'd0);
    chk("clear_empty", 32'(empty), 32'd1);
    chk("clear_rd_hold", 32'(rd_data), 32'd4);
    chk("clear_count", 32'(match_count), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
